// File: rtl/fetch_seq_if.sv
// Program-memory / decoder side bus of the fetch sequencer.
// The master modport is the sequencer; the slave modport is memory, decoder and flag logic.
interface fetch_seq_if #(
  parameter int AW = 12
);
  logic [3:0]    D;
  logic          JMP;
  logic          LDD;
  logic          TAKEN;
  logic          HALT;
  logic [AW-1:0] A;
  logic          IR_LE;
  logic [3:0]    OPR;
  logic          OPR_V;
  logic          BUSY;

  modport master (
    input  D, JMP, LDD, TAKEN, HALT,
    output A, IR_LE, OPR, OPR_V, BUSY
  );

  modport slave (
    output D, JMP, LDD, TAKEN, HALT,
    input  A, IR_LE, OPR, OPR_V, BUSY
  );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer and program counter for the 4-bit core.
// Fetches the opcode nibble, then any in-line jump-target or load-immediate operand nibbles.
module fetch_seq #(
  parameter int            AW      = 12,
  parameter logic [AW-1:0] RST_VEC = {AW{1'b0}}
) (
  input logic         CLK,
  input logic         RST,
  fetch_seq_if.master bus
);

  localparam int            NJ       = AW / 4;
  localparam int            CW       = (NJ > 1) ? $clog2(NJ) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NJ - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PC_ONE   = AW'(1);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    OPND   = 2'd2,
    JTGT   = 2'd3
  } seqState;

  seqState       stateReg, stateNext;
  logic [AW-1:0] pcReg, pcNext, pcInc, jumpTgt;
  logic [CW-1:0] cntReg, cntNext;
  logic [AW-1:0] tgtReg, tgtNext;
  logic [3:0]    oprReg, oprNext;
  logic          oprVReg, oprVNext;
  logic          busyReg, busyNext;
  logic          irLe;

  assign pcInc = pcReg + PC_ONE;

  // Next-state, PC, operand and latch-enable decode
  always_comb begin
    stateNext = stateReg;
    pcNext    = pcReg;
    cntNext   = cntReg;
    tgtNext   = tgtReg;
    oprNext   = oprReg;
    irLe      = 1'b0;
    // Final target: stored low nibbles plus the nibble on D this cycle
    jumpTgt            = tgtReg;
    jumpTgt[AW-1 -: 4] = bus.D;
    case (stateReg)
      FETCH: begin
        if (bus.HALT) begin
          stateNext = FETCH;
        end else begin
          irLe      = 1'b1;
          pcNext    = pcInc;
          stateNext = DECODE;
        end
      end
      DECODE: begin
        if (bus.JMP) begin
          cntNext   = {CW{1'b0}};
          stateNext = JTGT;
        end else if (bus.LDD) begin
          stateNext = OPND;
        end else begin
          stateNext = FETCH;
        end
      end
      OPND: begin
        oprNext   = bus.D;
        pcNext    = pcInc;
        stateNext = FETCH;
      end
      JTGT: begin
        tgtNext[{cntReg, 2'b00} +: 4] = bus.D;
        if (cntReg == CNT_LAST) begin
          pcNext    = bus.TAKEN ? jumpTgt : pcInc;
          cntNext   = {CW{1'b0}};
          stateNext = FETCH;
        end else begin
          pcNext    = pcInc;
          cntNext   = cntReg + CNT_ONE;
          stateNext = JTGT;
        end
      end
      default: begin
        stateNext = FETCH;
      end
    endcase
    oprVNext = (stateReg == OPND);
    busyNext = (stateNext != FETCH);
  end

  // Sequencer state registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      stateReg <= FETCH;
      pcReg    <= RST_VEC;
      cntReg   <= {CW{1'b0}};
      tgtReg   <= {AW{1'b0}};
      oprReg   <= 4'h0;
      oprVReg  <= 1'b0;
      busyReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
      cntReg   <= cntNext;
      tgtReg   <= tgtNext;
      oprReg   <= oprNext;
      oprVReg  <= oprVNext;
      busyReg  <= busyNext;
    end
  end

  assign bus.A     = pcReg;
  assign bus.IR_LE = irLe & ~RST;
  assign bus.OPR   = oprReg;
  assign bus.OPR_V = oprVReg;
  assign bus.BUSY  = busyReg;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a cycle-by-cycle trace table through a small program,
// plus a hand-written reset-during-jump sequence.
module tb_fetch_seq;

  logic CLK = 1'b0;
  logic RST;
  fetch_seq_if #(.AW(12)) bus ();

  fetch_seq #(.AW(12), .RST_VEC(12'h000)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Program memory and a minimal decoder: opcode 0xC = jump, 0x8 = load-immediate
  logic [3:0] mem [0:4095];
  logic [3:0] opLatch = 4'h0;
  assign bus.D   = mem[bus.A];
  assign bus.JMP = (opLatch == 4'hC);
  assign bus.LDD = (opLatch == 4'h8);

  always_ff @(posedge CLK) begin
    if (bus.IR_LE) opLatch <= bus.D;
  end

  typedef struct {
    logic        rst;
    logic        halt;
    logic        taken;
    logic [11:0] a;
    logic        irLe;
    logic        busy;
    logic        oprV;
    logic [3:0]  opr;
  } vecRow;

  vecRow rows[$];
  int nTests = 0;
  int nFail  = 0;

  task automatic addRow(input logic rst, input logic halt, input logic taken, input logic [11:0] a,
                        input logic irLe, input logic busy, input logic oprV, input logic [3:0] opr);
    vecRow r;
    r.rst = rst; r.halt = halt; r.taken = taken; r.a = a;
    r.irLe = irLe; r.busy = busy; r.oprV = oprV; r.opr = opr;
    rows.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [11:0] a, input logic irLe,
                          input logic busy, input logic oprV, input logic [3:0] opr);
    check({tag, " A"},     32'(bus.A),     32'(a));
    check({tag, " IR_LE"}, 32'(bus.IR_LE), 32'(irLe));
    check({tag, " BUSY"},  32'(bus.BUSY),  32'(busy));
    check({tag, " OPR_V"}, 32'(bus.OPR_V), 32'(oprV));
    check({tag, " OPR"},   32'(bus.OPR),   32'(opr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
    mem[12'h004] = 4'hC; mem[12'h005] = 4'h0; mem[12'h006] = 4'h1; mem[12'h007] = 4'h0;
    mem[12'h010] = 4'h8; mem[12'h011] = 4'hA;
    mem[12'h012] = 4'hC; mem[12'h013] = 4'h0; mem[12'h014] = 4'h2; mem[12'h015] = 4'h0;
    mem[12'h020] = 4'hC; mem[12'h021] = 4'h5; mem[12'h022] = 4'h3; mem[12'h023] = 4'h7;
    mem[12'h735] = 4'hC; mem[12'h736] = 4'h0; mem[12'h737] = 4'h2; mem[12'h738] = 4'h0;
    mem[12'h024] = 4'hC; mem[12'h025] = 4'h0; mem[12'h026] = 4'h4; mem[12'h027] = 4'h0;
    mem[12'h040] = 4'hC; mem[12'h041] = 4'hE; mem[12'h042] = 4'hF; mem[12'h043] = 4'hF;
    mem[12'hFFE] = 4'hC; mem[12'hFFF] = 4'h9;

    //     rst   halt  taken A       IR    BUSY  OPR_V OPR
    addRow(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'h0); // second reset cycle
    addRow(1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4'h0);
    addRow(1'b0, 1'b0, 1'b0, 12'h001, 1'b0, 1'b1, 1'b0, 4'h0);
    addRow(1'b0, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0, 1'b0, 4'h0);
    addRow(1'b0, 1'b0, 1'b0, 12'h002, 1'b0, 1'b1, 1'b0, 4'h0);
    addRow(1'b0, 1'b0, 1'b0, 12'h002, 1'b1, 1'b0, 1'b0, 4'h0);
    addRow(1'b0, 1'b0, 1'b0, 12'h003, 1'b0, 1'b1, 1'b0, 4'h0);
    addRow(1'b0, 1'b0, 1'b0, 12'h003, 1'b1, 1'b0, 1'b0, 4'h0);
    addRow(1'b0, 1'b0, 1'b0, 12'h004, 1'b0, 1'b1, 1'b0, 4'h0);
    addRow(1'b0, 1'b0, 1'b0, 12'h004, 1'b1, 1'b0, 1'b0, 4'h0); // JMP -> 0x010
    addRow(1'b0, 1'b0, 1'b0, 12'h005, 1'b0, 1'b1, 1'b0, 4'h0);
    addRow(1'b0, 1'b0, 1'b0, 12'h005, 1'b0, 1'b1, 1'b0, 4'h0);
    addRow(1'b0, 1'b0, 1'b0, 12'h006, 1'b0, 1'b1, 1'b0, 4'h0);
    addRow(1'b0, 1'b0, 1'b1, 12'h007, 1'b0, 1'b1, 1'b0, 4'h0);
    addRow(1'b0, 1'b0, 1'b0, 12'h010, 1'b1, 1'b0, 1'b0, 4'h0); // LDD
    addRow(1'b0, 1'b0, 1'b0, 12'h011, 1'b0, 1'b1, 1'b0, 4'h0);
    addRow(1'b0, 1'b0, 1'b0, 12'h011, 1'b0, 1'b1, 1'b0, 4'h0); // OPND
    addRow(1'b0, 1'b0, 1'b0, 12'h012, 1'b1, 1'b0, 1'b1, 4'hA); // JMP -> 0x020
    addRow(1'b0, 1'b0, 1'b0, 12'h013, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h013, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h014, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b1, 12'h015, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h020, 1'b1, 1'b0, 1'b0, 4'hA); // JMP 5,3,7 taken
    addRow(1'b0, 1'b0, 1'b0, 12'h021, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h021, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h022, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b1, 12'h023, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h735, 1'b1, 1'b0, 1'b0, 4'hA); // JMP back to 0x020
    addRow(1'b0, 1'b0, 1'b0, 12'h736, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h736, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h737, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b1, 12'h738, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h020, 1'b1, 1'b0, 1'b0, 4'hA); // JMP 5,3,7 not taken
    addRow(1'b0, 1'b0, 1'b0, 12'h021, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h021, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h022, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h023, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h024, 1'b1, 1'b0, 1'b0, 4'hA); // JMP -> 0x040
    addRow(1'b0, 1'b0, 1'b0, 12'h025, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h025, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h026, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b1, 12'h027, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b1, 1'b0, 12'h040, 1'b0, 1'b0, 1'b0, 4'hA); // HALT x3 in FETCH
    addRow(1'b0, 1'b1, 1'b0, 12'h040, 1'b0, 1'b0, 1'b0, 4'hA);
    addRow(1'b0, 1'b1, 1'b0, 12'h040, 1'b0, 1'b0, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h040, 1'b1, 1'b0, 1'b0, 4'hA); // JMP -> 0xFFE, HALT ignored
    addRow(1'b0, 1'b1, 1'b0, 12'h041, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b1, 1'b0, 12'h041, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b1, 1'b0, 12'h042, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b1, 1'b1, 12'h043, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'hFFE, 1'b1, 1'b0, 1'b0, 4'hA); // JMP across wrap, not taken
    addRow(1'b0, 1'b0, 1'b0, 12'hFFF, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'hFFF, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h001, 1'b0, 1'b1, 1'b0, 4'hA);
    addRow(1'b0, 1'b0, 1'b0, 12'h002, 1'b1, 1'b0, 1'b0, 4'hA);

    RST = 1'b1;
    bus.HALT = 1'b0;
    bus.TAKEN = 1'b0;
    @(posedge CLK);

    foreach (rows[i]) begin
      @(negedge CLK);
      RST       = rows[i].rst;
      bus.HALT  = rows[i].halt;
      bus.TAKEN = rows[i].taken;
      #1;
      checkAll($sformatf("row%0d", i), rows[i].a, rows[i].irLe, rows[i].busy, rows[i].oprV, rows[i].opr);
    end

    // Reset during the second jump-operand cycle of the JMP at 0x004
    bus.HALT  = 1'b0;
    bus.TAKEN = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge CLK);
      #1;
      if (bus.A == 12'h006 && bus.BUSY) found = 1'b1;
    end
    check("reach second JTGT", 32'(found), 32'(1));
    RST = 1'b1;
    #1;
    check("midrst IR_LE", 32'(bus.IR_LE), 32'(0));
    @(negedge CLK);
    #1;
    checkAll("midrst", 12'h000, 1'b0, 1'b0, 1'b0, 4'h0);
    RST = 1'b0;
    #1;
    checkAll("postrst fetch", 12'h000, 1'b1, 1'b0, 1'b0, 4'h0);
    @(negedge CLK);
    #1;
    checkAll("postrst decode", 12'h001, 1'b0, 1'b1, 1'b0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
